// File: rtl/capac_pkg.sv
// capac_pkg: shared constants for the MAC result requantiser.
//   MAC_OUT_W      width of the MAC accumulator result
//   OP_W           width of a MAC operand (the requantised format)
//   REQ_SHIFT_DEF  default arithmetic right shift applied on requantisation
//   OP_MAX/OP_MIN  saturation limits of an OP_W-bit signed operand
package capac_pkg;

    localparam int MAC_OUT_W     = 24;
    localparam int OP_W          = 20;
    localparam int REQ_SHIFT_DEF = 4;

    localparam logic signed [OP_W-1:0] OP_MAX = {1'b0, {(OP_W-1){1'b1}}};
    localparam logic signed [OP_W-1:0] OP_MIN = {1'b1, {(OP_W-1){1'b0}}};

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO.
//   clk, rst      clock, synchronous active-low reset (clears storage too)
//   clear         flush pointers and count; wins over push/pop
//   push, wdata   write request; caller must not push when full unless popping
//   pop           read request; caller must not pop when empty
//   rdata         head entry, valid while !empty
//   count/full/empty  occupancy status
module sync_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);  // wraps: DEPTH is a power of 2
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mac_requant_fifo.sv
// mac_requant_fifo: captures MAC results on done, requantises them
// (arithmetic shift, round-half-up, saturate) and queues them for reuse
// as operands behind a valid/ready interface. The MAC cannot be stalled,
// so a result arriving at a full FIFO is dropped and flagged.
//   clk, rst            clock, synchronous active-low reset
//   clear               flush FIFO and pipeline, sticky flags kept
//   in_data, in_valid   MAC result and its one-cycle done strobe
//   out_data, out_valid, out_ready   FWFT head and handshake
//   count, full         FIFO occupancy
//   overflow, sat_flag  sticky: word dropped / saturated word written
module mac_requant_fifo
    import capac_pkg::*;
#(
    parameter int IN_W  = MAC_OUT_W,
    parameter int OUT_W = OP_W,
    parameter int SHIFT = REQ_SHIFT_DEF,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             overflow,
    output logic             sat_flag
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int RW = IN_W + 1;
    localparam logic signed [RW-1:0] RND =
        RW'((SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0);
    localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_data_q,  s1_data_d;
    logic             s1_sat_q,   s1_sat_d;
    logic             overflow_q, overflow_d;
    logic             sat_flag_q, sat_flag_d;

    logic signed [RW-1:0] rnd, shf;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Stage 1: requantise
    always_comb begin
        rnd        = $signed({in_data[IN_W-1], in_data}) + RND;
        shf        = rnd >>> SHIFT;
        s1_valid_d = in_valid && !clear;
        s1_data_d  = s1_data_q;
        s1_sat_d   = s1_sat_q;
        if (in_valid) begin
            if (shf > SAT_MAX) begin
                s1_data_d = SAT_MAX[OUT_W-1:0];
                s1_sat_d  = 1'b1;
            end else if (shf < SAT_MIN) begin
                s1_data_d = SAT_MIN[OUT_W-1:0];
                s1_sat_d  = 1'b1;
            end else begin
                s1_data_d = shf[OUT_W-1:0];
                s1_sat_d  = 1'b0;
            end
        end
    end

    // Stage 2: FIFO write. A pop in the same cycle frees the slot, so a
    // full FIFO still accepts the push when the consumer is draining.
    always_comb begin
        fifo_pop   = !fifo_empty && out_ready && !clear;
        fifo_push  = s1_valid_q && (!fifo_full || fifo_pop) && !clear;
        overflow_d = overflow_q || (s1_valid_q && fifo_full && !fifo_pop && !clear);
        sat_flag_d = sat_flag_q || (fifo_push && s1_sat_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sat_q   <= 1'b0;
            overflow_q <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sat_q   <= s1_sat_d;
            overflow_q <= overflow_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (s1_data_q),
        .rdata (out_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign full      = fifo_full;
    assign overflow  = overflow_q;
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_mac_requant_fifo.sv
module tb_mac_requant_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [23:0] in_data;
    logic        in_valid;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    logic        sat_flag;

    int checks   = 0;
    int failures = 0;

    mac_requant_fifo #(
        .IN_W  (24),
        .OUT_W (20),
        .SHIFT (4),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] din;
        logic [19:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[8];

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic push_one(input logic [23:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count",     32'(count),     0);
        chk("rst_full",      32'(full),      0);
        chk("rst_overflow",  32'(overflow),  0);
        chk("rst_sat",       32'(sat_flag),  0);
        chk("rst_out_data",  32'(out_data),  0);

        // Rounding, sign and saturation vectors, one word each, from reset
        vecs[0] = '{24'h000018, 20'h00002, 1'b0};
        vecs[1] = '{24'h000017, 20'h00001, 1'b0};
        vecs[2] = '{24'hFFFFE8, 20'hFFFFF, 1'b0};
        vecs[3] = '{24'h800000, 20'h80000, 1'b0};
        vecs[4] = '{24'h7FFFFF, 20'h7FFFF, 1'b1};
        vecs[5] = '{24'h000008, 20'h00001, 1'b0};  // exact half rounds up
        vecs[6] = '{24'hFFFFF8, 20'h00000, 1'b0};  // -0.5 rounds up to 0
        vecs[7] = '{24'hFFFFF7, 20'hFFFFF, 1'b0};  // -0.5625 -> -1
        for (int i = 0; i < 8; i++) begin
            do_reset();
            push_one(vecs[i].din);
            chk($sformatf("vec%0d_lat1", i), 32'(out_valid), 0);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_data", i),  32'(out_data),  32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_sat", i),   32'(sat_flag),  32'(vecs[i].exp_sat));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("vec%0d_popped", i), 32'(out_valid), 0);
        end

        // Back-to-back rounding pair, consumer always ready
        do_reset();
        out_ready = 1'b1;
        push_one(24'h000018);
        push_one(24'h000017);
        chk("pair_first", 32'(out_data), 32'h2);
        tick();
        chk("pair_second", 32'(out_data), 32'h1);
        chk("pair_sat", 32'(sat_flag), 0);
        tick();
        chk("pair_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Fill and overflow: 9 pushes into 8 entries
        do_reset();
        for (int i = 1; i <= 9; i++) push_one(24'(i << 4));
        tick();
        tick();
        chk("ovf_count", 32'(count),    8);
        chk("ovf_full",  32'(full),     1);
        chk("ovf_flag",  32'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("drain%0d_data", i),  32'(out_data),  32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_count", 32'(count),     0);

        // Simultaneous push and pop at full
        do_reset();
        for (int i = 1; i <= 8; i++) push_one(24'(i << 4));
        tick();
        chk("pp_fill", 32'(count), 8);
        push_one(24'(10 << 4));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_count", 32'(count),    8);
        chk("pp_full",  32'(full),     1);
        chk("pp_ovf",   32'(overflow), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_drain%0d", i), 32'(out_data), (i < 7) ? 32'(i + 2) : 32'd10);
            tick();
        end
        out_ready = 1'b0;
        chk("pp_empty", 32'(out_valid), 0);

        // clear mid-stream keeps sticky flags; reset clears them
        do_reset();
        push_one(24'h7FFFFF);
        for (int i = 2; i <= 9; i++) push_one(24'(i << 4));
        tick();
        chk("clr_pre_sat", 32'(sat_flag), 1);
        chk("clr_pre_ovf", 32'(overflow), 1);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        chk("clr_pre_count", 32'(count), 5);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'h000100;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_count", 32'(count),     0);
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_ovf",   32'(overflow),  1);
        chk("clr_sat",   32'(sat_flag),  1);
        tick();
        chk("clr_in_discarded", 32'(count), 0);
        // clear one edge after capture flushes the stage-1 word
        push_one(24'h000200);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("clr_s1_flushed", 32'(count), 0);
        do_reset();
        chk("rst2_ovf",   32'(overflow), 0);
        chk("rst2_sat",   32'(sat_flag), 0);
        chk("rst2_data",  32'(out_data), 0);
        chk("rst2_count", 32'(count),    0);

        // Exact latency and pointer wrap, every word popped immediately
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            push_one(24'(i << 4));
            chk($sformatf("wrap%0d_lat", i), 32'(out_valid), 0);
            tick();
            chk($sformatf("wrap%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("wrap%0d_data", i),  32'(out_data),  32'(i));
            tick();
            chk($sformatf("wrap%0d_gone", i), 32'(out_valid), 0);
        end
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
